mpmc11_wdf_beat_seq: RTL

- Downstream partner of the app_wdf_wren generator.
- Latches one cache-line write (data + byte enables) from the controller state machine and presents it to the MIG write-data FIFO one beat at a time.
- Advances a beat on every wdf_wren strobe, flags the last beat with app_wdf_end, and pulses done when the line is fully pushed.
- Sits between the mpmc11 write-path state machine and the MIG app_wdf_* interface.

---
 rtl/mpmc11_wdf_beat_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mpmc11_wdf_beat_seq.sv
// mpmc11_wdf_beat_seq
// Loads one cache-line write (data plus byte enables) from the mpmc11 write-path
// state machine. It then presents the line to the MIG write-data FIFO one beat at
// a time. The sequencer advances on each wren strobe and raises app_wdf_end on
// the last beat. It pulses done for one cycle after the final beat is accepted.
//
// Ports:
//   clk, rst_n      controller clock, asynchronous active-low reset
//   start           one-cycle load request, honoured only when idle
//   line_dat        line data, beat k = line_dat[k*DW +: DW]
//   line_sel        line byte enables, 1 = write byte
//   wren            app_wdf_wren, already qualified by wdf_rdy
//   app_wdf_data    data of the presented beat
//   app_wdf_mask    mask of the presented beat, 1 = do not write
//   app_wdf_end     presented beat is the last beat of the line
//   busy            line held, beats outstanding
//   done            one-cycle pulse after the final beat is accepted
//   beat_cnt        index of the presented beat
//   stall_cnt       BUSY cycles with wren low (saturating, cumulative)
//
// Build option: define MPMC11_WDF_STALL_CNT_EN to enable the stall counter.
// When the macro is undefined, stall_cnt is tied to zero.

module mpmc11_wdf_beat_seq #(
  parameter int unsigned DW    = 128,
  parameter int unsigned NBEAT = 2,
  parameter int unsigned LW    = DW * NBEAT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [LW-1:0]   line_dat,
  input  logic [LW/8-1:0] line_sel,
  input  logic            wren,
  output logic [DW-1:0]   app_wdf_data,
  output logic [DW/8-1:0] app_wdf_mask,
  output logic            app_wdf_end,
  output logic            busy,
  output logic            done,
  output logic [2:0]      beat_cnt,
  output logic [31:0]     stall_cnt
);

  localparam logic [2:0] LAST = 3'(NBEAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   dat_q, dat_d;
  logic [LW/8-1:0] sel_q, sel_d;
  logic [2:0]      cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dat_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dat_d   = line_dat;
          sel_d   = line_sel;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (wren) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat select is a compare-and-OR mux rather than a variable part-select.
  // This keeps the index arithmetic at natural widths for any NBEAT.
  logic [DW-1:0]   beat_dat;
  logic [DW/8-1:0] beat_sel;

  always_comb begin
    beat_dat = '0;
    beat_sel = '0;
    for (int unsigned k = 0; k < NBEAT; k++) begin
      if (cnt_q == 3'(k)) begin
        beat_dat = dat_q[k*DW +: DW];
        beat_sel = sel_q[k*(DW/8) +: DW/8];
      end
    end
  end

  assign busy         = (state_q == BUSY);
  assign done         = (state_q == DONE);
  assign beat_cnt     = cnt_q;
  assign app_wdf_data = busy ? beat_dat : '0;
  assign app_wdf_mask = busy ? ~beat_sel : '1;
  assign app_wdf_end  = busy && (cnt_q == LAST);

`ifdef MPMC11_WDF_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (busy && !wren && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
